// File: rtl/priority_encoder_pkg.sv
// Shared constants and helpers for the pipelined priority encoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package priority_encoder_pkg;

  localparam int PE_WIDTH_DEFAULT = 16;
  localparam int PE_SEG_W_DEFAULT = 4;
  localparam int PE_WIDTH_MAX     = 256;

  // Binary index of a one-hot word; returns 0 for an all-zero word.
  function automatic logic [7:0] onehot_to_idx(input logic [PE_WIDTH_MAX-1:0] oh);
    logic [7:0] idx;
    idx = '0;
    for (int i = 0; i < PE_WIDTH_MAX; i++) begin
      if (oh[i]) idx = idx | 8'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/priority_encoder_seg.sv
// Segment finder: one-hot highest/lowest set bit of a SEG_W slice, plus any-set.
// Latency: combinational.
// Backpressure: none (no state).
module priority_encoder_seg #(
  parameter int SEG_W = 4
) (
  input  logic [SEG_W-1:0] seg_i,
  output logic [SEG_W-1:0] left_o,
  output logic [SEG_W-1:0] right_o,
  output logic             any_o
);

  // Ascending scan for the highest bit, descending scan for the lowest; last hit wins.
  always_comb begin
    left_o  = '0;
    right_o = '0;
    for (int i = 0; i < SEG_W; i++) begin
      if (seg_i[i]) begin
        left_o    = '0;
        left_o[i] = 1'b1;
      end
    end
    for (int i = SEG_W - 1; i >= 0; i--) begin
      if (seg_i[i]) begin
        right_o    = '0;
        right_o[i] = 1'b1;
      end
    end
    any_o = |seg_i;
  end

endmodule

// File: rtl/priority_encoder_pipe.sv
// Two-stage left/right priority encoder (one-hot MSB/LSB masks + zero flag); optional indices via PRIORITY_ENCODER_PIPE_IDX_EN.
// Latency: 2 cycles input transfer to data_val_o; 1 word/cycle throughput.
// Backpressure: valid/ready; holds 2 words under stall, data_rdy_o has no path from data_val_i.
module priority_encoder_pipe
  import priority_encoder_pkg::*;
#(
  parameter int WIDTH = PE_WIDTH_DEFAULT,
  parameter int SEG_W = PE_SEG_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] data_i,
  input  logic             data_val_i,
  output logic             data_rdy_o,
  output logic [WIDTH-1:0] data_left_o,
  output logic [WIDTH-1:0] data_right_o,
  output logic             data_zero_o,
  output logic             data_val_o,
  input  logic             data_rdy_i
`ifdef PRIORITY_ENCODER_PIPE_IDX_EN
  ,
  output logic [$clog2(WIDTH)-1:0] data_left_idx_o,
  output logic [$clog2(WIDTH)-1:0] data_right_idx_o
`endif
);

  localparam int NSEG = WIDTH / SEG_W;

  // Parameter legality, rejected at elaboration.
  if (WIDTH < 2 || WIDTH > PE_WIDTH_MAX) begin : g_bad_width
    $error("priority_encoder_pipe: WIDTH must be in 2..256");
  end
  if (SEG_W < 2 || SEG_W > WIDTH || (SEG_W & (SEG_W - 1)) != 0) begin : g_bad_seg
    $error("priority_encoder_pipe: SEG_W must be a power of two in 2..WIDTH");
  end
  if ((WIDTH % SEG_W) != 0) begin : g_bad_mult
    $error("priority_encoder_pipe: WIDTH must be a multiple of SEG_W");
  end

  logic s1_val, s2_val, s1_en, s2_en;

  logic [NSEG-1:0][SEG_W-1:0] seg_left_c, seg_right_c;
  logic [NSEG-1:0]            seg_any_c;
  logic [NSEG-1:0][SEG_W-1:0] seg_left_q, seg_right_q;
  logic [NSEG-1:0]            seg_any_q;

  logic [WIDTH-1:0] left_c, right_c;
  logic             zero_c;

  // Enables come only from registered valids and downstream ready.
  always_comb begin
    s2_en      = !s2_val || data_rdy_i;
    s1_en      = !s1_val || s2_en;
    data_rdy_o = s1_en;
    data_val_o = s2_val;
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    priority_encoder_seg #(.SEG_W(SEG_W)) u_seg (
      .seg_i  (data_i[k*SEG_W +: SEG_W]),
      .left_o (seg_left_c[k]),
      .right_o(seg_right_c[k]),
      .any_o  (seg_any_c[k])
    );
  end

  // Stage 1: capture per-segment results; data only loads on an accepted word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_val      <= 1'b0;
      seg_left_q  <= '0;
      seg_right_q <= '0;
      seg_any_q   <= '0;
    end else if (s1_en) begin
      s1_val <= data_val_i;
      if (data_val_i) begin
        seg_left_q  <= seg_left_c;
        seg_right_q <= seg_right_c;
        seg_any_q   <= seg_any_c;
      end
    end
  end

  // Stage 2 combine: highest occupied segment supplies left, lowest supplies right.
  always_comb begin
    left_c  = '0;
    right_c = '0;
    for (int k = 0; k < NSEG; k++) begin
      if (seg_any_q[k]) begin
        left_c                     = '0;
        left_c[k*SEG_W +: SEG_W]   = seg_left_q[k];
      end
    end
    for (int k = NSEG - 1; k >= 0; k--) begin
      if (seg_any_q[k]) begin
        right_c                    = '0;
        right_c[k*SEG_W +: SEG_W]  = seg_right_q[k];
      end
    end
    zero_c = ~|seg_any_q;
  end

  // Stage 2 output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_val       <= 1'b0;
      data_left_o  <= '0;
      data_right_o <= '0;
      data_zero_o  <= 1'b0;
    end else if (s2_en) begin
      s2_val <= s1_val;
      if (s1_val) begin
        data_left_o  <= left_c;
        data_right_o <= right_c;
        data_zero_o  <= zero_c;
      end
    end
  end

`ifdef PRIORITY_ENCODER_PIPE_IDX_EN
  localparam int IDX_W = $clog2(WIDTH);
  logic [IDX_W-1:0] left_idx_c, right_idx_c;

  // One-hot masks are zero for an empty word, so the indices fall to 0 too.
  always_comb begin
    left_idx_c  = IDX_W'(onehot_to_idx(PE_WIDTH_MAX'(left_c)));
    right_idx_c = IDX_W'(onehot_to_idx(PE_WIDTH_MAX'(right_c)));
  end

  // Index registers track the mask registers exactly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_left_idx_o  <= '0;
      data_right_idx_o <= '0;
    end else if (s2_en && s1_val) begin
      data_left_idx_o  <= left_idx_c;
      data_right_idx_o <= right_idx_c;
    end
  end
`endif

endmodule
